bus_reg_arbiter: RTL and testbench

- Register-bus fan-out controller sitting between the AXI-to-IPIF Bus2IP slave port and up to NUM_PORTS sub-block register controllers (data processor controllers, lookup-table controllers, etc.).
- Decodes a select field from Bus2IP_Addr and forwards one transaction at a time to the selected sub-port.
- Returns the sub-port's data and ack upstream.
- Guarantees an upstream ack on every access: unmapped selects and sub-ports that never ack are terminated with an error response.

---
 rtl/bus_reg_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_bus_reg_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_reg_arbiter.sv
// ============================================================================
// Module  : bus_reg_arbiter
// Purpose : Fans one Bus2IP register slave port out to NUM_PORTS sub-block
//           register controllers; every upstream access is always acked.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_reg_arbiter #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_PORTS          = 4,
    parameter int SEL_LSB            = 8,
    parameter int SEL_WIDTH          = 2,
    parameter int TIMEOUT            = 64,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                                    Bus2IP_Clk,
    input  logic                                    Bus2IP_Resetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]           Bus2IP_Addr,
    input  logic                                    Bus2IP_CS,
    input  logic                                    Bus2IP_RNW,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]           Bus2IP_Data,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]         Bus2IP_BE,
    output logic [C_S_AXI_DATA_WIDTH-1:0]           IP2Bus_Data,
    output logic                                    IP2Bus_RdAck,
    output logic                                    IP2Bus_WrAck,
    output logic                                    IP2Bus_Error,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]           sub_Bus2IP_Addr,
    output logic                                    sub_Bus2IP_RNW,
    output logic [C_S_AXI_DATA_WIDTH-1:0]           sub_Bus2IP_Data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]         sub_Bus2IP_BE,
    output logic [NUM_PORTS-1:0]                    sub_Bus2IP_CS,
    input  logic [NUM_PORTS*C_S_AXI_DATA_WIDTH-1:0] sub_IP2Bus_Data,
    input  logic [NUM_PORTS-1:0]                    sub_IP2Bus_RdAck,
    input  logic [NUM_PORTS-1:0]                    sub_IP2Bus_WrAck,
    output logic [15:0]                             timeout_cnt,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]           last_err_addr
);

    localparam int c_num_sel = 2 ** SEL_WIDTH;
    localparam int c_timer_w = $clog2(TIMEOUT);
    localparam logic [c_timer_w-1:0] c_timer_max = c_timer_w'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_ACK     = 3'd2,
        S_ERR     = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t                              r_state;
    state_t                              w_next_state;
    logic [C_S_AXI_ADDR_WIDTH-1:0]       r_addr;
    logic                                r_rnw;
    logic [C_S_AXI_DATA_WIDTH-1:0]       r_wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]     r_be;
    logic [SEL_WIDTH-1:0]                r_sel;
    logic [NUM_PORTS-1:0]                r_cs;
    logic [c_timer_w-1:0]                r_timer;
    logic                                r_timed_out;
    logic [C_S_AXI_DATA_WIDTH-1:0]       r_rdata;
    logic                                r_rdack;
    logic                                r_wrack;
    logic                                r_err;
    logic [15:0]                         r_timeout_cnt;
    logic [C_S_AXI_ADDR_WIDTH-1:0]       r_last_err_addr;

    logic [SEL_WIDTH-1:0]                w_sel;
    logic                                w_sel_valid;
    logic [NUM_PORTS-1:0]                w_cs_onehot;
    logic [c_num_sel-1:0]                w_rdack_pad;
    logic [c_num_sel-1:0]                w_wrack_pad;
    logic [C_S_AXI_DATA_WIDTH-1:0]       w_rdata_pad [c_num_sel];
    logic                                w_match_ack;
    logic                                w_expired;
    logic                                w_sub_quiet;

    assign w_sel       = Bus2IP_Addr[SEL_LSB +: SEL_WIDTH];
    assign w_sel_valid = (32'(w_sel) < NUM_PORTS);

    // Pad per-port returns to the full select range so an unmapped select reads as idle.
    always_comb begin
        w_rdack_pad = '0;
        w_wrack_pad = '0;
        w_cs_onehot = '0;
        for (int i = 0; i < c_num_sel; i++) begin
            w_rdata_pad[i] = '0;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_rdack_pad[i] = sub_IP2Bus_RdAck[i];
            w_wrack_pad[i] = sub_IP2Bus_WrAck[i];
            w_rdata_pad[i] = sub_IP2Bus_Data[i*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH];
            w_cs_onehot[i] = (w_sel == SEL_WIDTH'(i));
        end
    end

    assign w_match_ack = r_rnw ? w_rdack_pad[r_sel] : w_wrack_pad[r_sel];
    assign w_expired   = (r_timer == c_timer_max);
    assign w_sub_quiet = ~w_rdack_pad[r_sel] & ~w_wrack_pad[r_sel];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (Bus2IP_CS) w_next_state = w_sel_valid ? S_ISSUE : S_ERR;
            S_ISSUE: begin
                if (w_match_ack)    w_next_state = S_ACK;
                else if (w_expired) w_next_state = S_ERR;
            end
            S_ACK:     w_next_state = S_RELEASE;
            S_ERR:     w_next_state = S_RELEASE;
            S_RELEASE: if (!Bus2IP_CS && w_sub_quiet) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_rnw           <= 1'b0;
            r_wdata         <= '0;
            r_be            <= '0;
            r_sel           <= '0;
            r_cs            <= '0;
            r_timer         <= '0;
            r_timed_out     <= 1'b0;
            r_rdata         <= '0;
            r_rdack         <= 1'b0;
            r_wrack         <= 1'b0;
            r_err           <= 1'b0;
            r_timeout_cnt   <= '0;
            r_last_err_addr <= '0;
        end else begin
            r_state <= w_next_state;
            // Acks are registered from the ACK/ERR state so they last exactly one cycle.
            r_rdack <= ((r_state == S_ACK) || (r_state == S_ERR)) & r_rnw;
            r_wrack <= ((r_state == S_ACK) || (r_state == S_ERR)) & ~r_rnw;
            r_err   <= (r_state == S_ERR);
            case (r_state)
                S_IDLE: begin
                    if (Bus2IP_CS) begin
                        r_addr      <= Bus2IP_Addr;
                        r_rnw       <= Bus2IP_RNW;
                        r_wdata     <= Bus2IP_Data;
                        r_be        <= Bus2IP_BE;
                        r_sel       <= w_sel;
                        r_cs        <= w_cs_onehot;
                        r_timer     <= '0;
                        r_timed_out <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (w_match_ack) begin
                        r_cs <= '0;
                        if (r_rnw) r_rdata <= w_rdata_pad[r_sel];
                    end else if (w_expired) begin
                        r_cs        <= '0;
                        r_timed_out <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_timer_w'(1);
                    end
                end
                S_ERR: begin
                    if (r_rnw) r_rdata <= ERR_DATA;
                    r_last_err_addr <= r_addr;
                    if (r_timed_out && (r_timeout_cnt != 16'hFFFF))
                        r_timeout_cnt <= r_timeout_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign IP2Bus_Data     = r_rdata;
    assign IP2Bus_RdAck    = r_rdack;
    assign IP2Bus_WrAck    = r_wrack;
    assign IP2Bus_Error    = r_err;
    assign sub_Bus2IP_Addr = r_addr;
    assign sub_Bus2IP_RNW  = r_rnw;
    assign sub_Bus2IP_Data = r_wdata;
    assign sub_Bus2IP_BE   = r_be;
    assign sub_Bus2IP_CS   = r_cs;
    assign timeout_cnt     = r_timeout_cnt;
    assign last_err_addr   = r_last_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_bus_reg_arbiter.sv
// ============================================================================
// Module  : tb_bus_reg_arbiter
// Purpose : Directed self-checking bench for bus_reg_arbiter (4-port and
//           3-port instances sharing the upstream address/data bus).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        rnw;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        cs_a;
    logic        cs_b;

    logic [31:0]  rdata_a, s_addr_a, s_data_a, lea_a;
    logic         rdack_a, wrack_a, err_a, s_rnw_a;
    logic [3:0]   s_be_a, s_cs_a;
    logic [15:0]  tcnt_a;
    logic [127:0] s_rd_a;
    logic [3:0]   s_rdack_a, s_wrack_a;

    logic [31:0]  rdata_b, s_addr_b, s_data_b, lea_b;
    logic         rdack_b, wrack_b, err_b, s_rnw_b;
    logic [3:0]   s_be_b;
    logic [2:0]   s_cs_b;
    logic [15:0]  tcnt_b;
    logic [95:0]  s_rd_b;
    logic [2:0]   s_rdack_b, s_wrack_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_reg_arbiter u_dut_a (
        .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n), .Bus2IP_Addr(addr), .Bus2IP_CS(cs_a),
        .Bus2IP_RNW(rnw), .Bus2IP_Data(wdata), .Bus2IP_BE(be),
        .IP2Bus_Data(rdata_a), .IP2Bus_RdAck(rdack_a), .IP2Bus_WrAck(wrack_a),
        .IP2Bus_Error(err_a), .sub_Bus2IP_Addr(s_addr_a), .sub_Bus2IP_RNW(s_rnw_a),
        .sub_Bus2IP_Data(s_data_a), .sub_Bus2IP_BE(s_be_a), .sub_Bus2IP_CS(s_cs_a),
        .sub_IP2Bus_Data(s_rd_a), .sub_IP2Bus_RdAck(s_rdack_a), .sub_IP2Bus_WrAck(s_wrack_a),
        .timeout_cnt(tcnt_a), .last_err_addr(lea_a)
    );

    bus_reg_arbiter #(.NUM_PORTS(3)) u_dut_b (
        .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n), .Bus2IP_Addr(addr), .Bus2IP_CS(cs_b),
        .Bus2IP_RNW(rnw), .Bus2IP_Data(wdata), .Bus2IP_BE(be),
        .IP2Bus_Data(rdata_b), .IP2Bus_RdAck(rdack_b), .IP2Bus_WrAck(wrack_b),
        .IP2Bus_Error(err_b), .sub_Bus2IP_Addr(s_addr_b), .sub_Bus2IP_RNW(s_rnw_b),
        .sub_Bus2IP_Data(s_data_b), .sub_Bus2IP_BE(s_be_b), .sub_Bus2IP_CS(s_cs_b),
        .sub_IP2Bus_Data(s_rd_b), .sub_IP2Bus_RdAck(s_rdack_b), .sub_IP2Bus_WrAck(s_wrack_b),
        .timeout_cnt(tcnt_b), .last_err_addr(lea_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cs_a = 1'b0; cs_b = 1'b0; addr = '0; rnw = 1'b0; wdata = '0; be = '0;
        s_rd_a = '0; s_rdack_a = '0; s_wrack_a = '0;
        s_rd_b = '0; s_rdack_b = '0; s_wrack_b = '0;
        repeat (3) tick();
        checks++;
        if ({rdack_a, wrack_a, err_a, s_cs_a, s_rnw_a} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl_a actual=%b required=00000000", {rdack_a, wrack_a, err_a, s_cs_a, s_rnw_a});
        end
        checks++;
        if ({rdata_a, s_addr_a, s_data_a, lea_a, tcnt_a} !== '0) begin
            failures++;
            $display("FAIL reset_data_a actual=%h required=0", {rdata_a, s_addr_a, s_data_a, lea_a, tcnt_a});
        end
        checks++;
        if ({rdack_b, wrack_b, err_b, s_cs_b, tcnt_b} !== '0) begin
            failures++;
            $display("FAIL reset_b actual=%h required=0", {rdack_b, wrack_b, err_b, s_cs_b, tcnt_b});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_port1();
        int ack_n = -1;
        int acks = 0;
        int wracks = 0;
        bit multi = 1'b0;
        logic [31:0] d = '0;
        logic e = 1'b1;
        addr = 32'h0000_0120; rnw = 1'b1; be = 4'hF; wdata = '0; cs_a = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (rdack_a) begin
                acks++;
                if (ack_n < 0) begin ack_n = n; d = rdata_a; e = err_a; end
                cs_a = 1'b0;
            end
            if (wrack_a) wracks++;
            if ($countones(s_cs_a) > 1) multi = 1'b1;
            if (n == 1) begin
                checks++;
                if (s_cs_a !== 4'b0010) begin
                    failures++; $display("FAIL rd1_sub_cs actual=%b required=0010", s_cs_a);
                end
                checks++;
                if (s_addr_a !== 32'h0000_0120 || s_rnw_a !== 1'b1) begin
                    failures++; $display("FAIL rd1_sub_addr actual=%h/%b required=00000120/1", s_addr_a, s_rnw_a);
                end
            end
            if (n == 8) begin
                checks++;
                if (s_cs_a !== 4'b0010) begin
                    failures++; $display("FAIL rd1_cs_held actual=%b required=0010", s_cs_a);
                end
            end
            if (n == 9) begin
                checks++;
                if (s_cs_a !== 4'b0000) begin
                    failures++; $display("FAIL rd1_cs_clear actual=%b required=0000", s_cs_a);
                end
            end
            s_rdack_a = '0; s_wrack_a = '0;
            // Wrong-direction ack on port 1 and a stray read ack on port 2 must be ignored.
            if (n == 4) begin s_wrack_a[1] = 1'b1; s_rdack_a[2] = 1'b1; end
            if (n == 8) begin s_rdack_a[1] = 1'b1; s_rd_a[32 +: 32] = 32'h0123ABCD; end
        end
        checks++;
        if (ack_n != 10 || acks != 1 || wracks != 0) begin
            failures++; $display("FAIL rd1_ack actual=n%0d/cnt%0d/wr%0d required=n10/cnt1/wr0", ack_n, acks, wracks);
        end
        checks++;
        if (d !== 32'h0123ABCD || e !== 1'b0) begin
            failures++; $display("FAIL rd1_data actual=%h/%b required=0123abcd/0", d, e);
        end
        checks++;
        if (multi) begin
            failures++; $display("FAIL rd1_onehot actual=multiple required=single");
        end
    endtask

    task automatic test_write_port0();
        int ack_n = -1;
        int acks = 0;
        int rdacks = 0;
        logic e = 1'b1;
        addr = 32'h0000_0018; rnw = 1'b0; wdata = 32'h0000_00FF; be = 4'b0011; cs_a = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (wrack_a) begin
                acks++;
                if (ack_n < 0) begin ack_n = n; e = err_a; end
                cs_a = 1'b0;
            end
            if (rdack_a) rdacks++;
            if (n == 1) begin
                checks++;
                if (s_cs_a !== 4'b0001 || s_data_a !== 32'h0000_00FF || s_be_a !== 4'b0011 || s_rnw_a !== 1'b0) begin
                    failures++;
                    $display("FAIL wr0_sub_bus actual=%b/%h/%b/%b required=0001/000000ff/0011/0", s_cs_a, s_data_a, s_be_a, s_rnw_a);
                end
            end
            s_wrack_a = '0;
            if (n == 2) s_wrack_a[0] = 1'b1;
        end
        checks++;
        if (ack_n != 4 || acks != 1 || rdacks != 0 || e !== 1'b0) begin
            failures++; $display("FAIL wr0_ack actual=n%0d/cnt%0d/rd%0d/err%b required=n4/cnt1/rd0/err0", ack_n, acks, rdacks, e);
        end
        checks++;
        if (rdata_a !== 32'h0123ABCD) begin
            failures++; $display("FAIL wr0_rdata_hold actual=%h required=0123abcd", rdata_a);
        end
    endtask

    task automatic test_timeout();
        int ack_n = -1;
        logic [31:0] d = '0;
        logic e = 1'b0;
        addr = 32'h0000_0300; rnw = 1'b1; cs_a = 1'b1;
        for (int n = 1; n <= 75; n++) begin
            tick();
            if (rdack_a && ack_n < 0) begin ack_n = n; d = rdata_a; e = err_a; cs_a = 1'b0; end
            if (n == 64) begin
                checks++;
                if (s_cs_a !== 4'b1000) begin
                    failures++; $display("FAIL to_cs_held actual=%b required=1000", s_cs_a);
                end
            end
            if (n == 65) begin
                checks++;
                if (s_cs_a !== 4'b0000) begin
                    failures++; $display("FAIL to_cs_clear actual=%b required=0000", s_cs_a);
                end
            end
        end
        checks++;
        if (ack_n != 66 || e !== 1'b1 || d !== 32'hDEADBEEF) begin
            failures++; $display("FAIL to_ack actual=n%0d/err%b/%h required=n66/err1/deadbeef", ack_n, e, d);
        end
        checks++;
        if (tcnt_a !== 16'd1 || lea_a !== 32'h0000_0300) begin
            failures++; $display("FAIL to_stats actual=%0d/%h required=1/00000300", tcnt_a, lea_a);
        end
    endtask

    task automatic test_unmapped();
        int ack_n = -1;
        bit any_cs = 1'b0;
        logic [31:0] d = '0;
        logic e = 1'b0;
        addr = 32'h0000_0300; rnw = 1'b1; cs_b = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (s_cs_b !== 3'b000) any_cs = 1'b1;
            if (rdack_b && ack_n < 0) begin ack_n = n; d = rdata_b; e = err_b; cs_b = 1'b0; end
        end
        checks++;
        if (ack_n != 2 || e !== 1'b1 || d !== 32'hDEADBEEF) begin
            failures++; $display("FAIL um_ack actual=n%0d/err%b/%h required=n2/err1/deadbeef", ack_n, e, d);
        end
        checks++;
        if (any_cs) begin
            failures++; $display("FAIL um_no_cs actual=asserted required=none");
        end
        checks++;
        if (tcnt_b !== 16'd0 || lea_b !== 32'h0000_0300) begin
            failures++; $display("FAIL um_stats actual=%0d/%h required=0/00000300", tcnt_b, lea_b);
        end
    endtask

    task automatic test_back_to_back();
        int ack_n = -1;
        int acks = 0;
        bit reissue = 1'b0;
        logic [31:0] d = '0;
        int ack2_n = -1;
        logic e2 = 1'b1;
        addr = 32'h0000_0200; rnw = 1'b1; cs_a = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (rdack_a) begin acks++; if (ack_n < 0) begin ack_n = n; d = rdata_a; end end
            if (n >= 4 && s_cs_a !== 4'b0000) reissue = 1'b1;
            s_rdack_a = '0;
            // Sub port keeps its ack up past completion; upstream keeps CS up past its ack.
            if (n >= 3 && n <= 6) begin s_rdack_a[2] = 1'b1; s_rd_a[64 +: 32] = 32'hCAFE0002; end
            if (n == 8) cs_a = 1'b0;
        end
        checks++;
        if (ack_n != 5 || acks != 1 || d !== 32'hCAFE0002) begin
            failures++; $display("FAIL b2b_ack actual=n%0d/cnt%0d/%h required=n5/cnt1/cafe0002", ack_n, acks, d);
        end
        checks++;
        if (reissue) begin
            failures++; $display("FAIL b2b_reissue actual=sub_cs_again required=none");
        end
        addr = 32'h0000_0304; rnw = 1'b0; wdata = 32'h55; be = 4'hF; cs_a = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (wrack_a && ack2_n < 0) begin ack2_n = n; e2 = err_a; cs_a = 1'b0; end
            s_wrack_a = '0;
            s_wrack_a[3] = s_cs_a[3];
        end
        checks++;
        if (ack2_n != 3 || e2 !== 1'b0) begin
            failures++; $display("FAIL b2b_next actual=n%0d/err%b required=n3/err0", ack2_n, e2);
        end
    endtask

    task automatic test_reset_mid();
        int ack_n = -1;
        logic [31:0] d = '0;
        addr = 32'h0000_0100; rnw = 1'b1; cs_a = 1'b1;
        repeat (5) tick();
        checks++;
        if (s_cs_a !== 4'b0010) begin
            failures++; $display("FAIL rst_pre_cs actual=%b required=0010", s_cs_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({s_cs_a, rdack_a, wrack_a, err_a} !== 7'd0 || rdata_a !== '0 || tcnt_a !== 16'd0 || lea_a !== '0) begin
            failures++;
            $display("FAIL rst_async actual=%b/%h/%0d/%h required=0/0/0/0", {s_cs_a, rdack_a, wrack_a, err_a}, rdata_a, tcnt_a, lea_a);
        end
        cs_a = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        cs_a = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (rdack_a && ack_n < 0) begin ack_n = n; d = rdata_a; cs_a = 1'b0; end
            s_rdack_a = '0;
            s_rdack_a[1] = s_cs_a[1];
            s_rd_a[32 +: 32] = 32'h1111_2222;
        end
        checks++;
        if (ack_n != 3 || d !== 32'h1111_2222) begin
            failures++; $display("FAIL rst_recover actual=n%0d/%h required=n3/11112222", ack_n, d);
        end
    endtask

    initial begin
        test_reset();
        test_read_port1();
        test_write_port0();
        test_timeout();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
